mem_bus_arbiter: RTL

//  Shares the single RAM/ROM memory bus between the CPU and a DMA/debug-loader port, one access per granted cycle.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter_starve_counter.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the memory bus arbiter.
//   bus_owner_t : which master owns the current bus slot.
//   *_DEF       : default widths and CPU burst limit.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_DMA  = 2'd2
  } bus_owner_t;

  localparam int unsigned ADDR_WIDTH_DEF    = 16;
  localparam int unsigned DATA_WIDTH_DEF    = 8;
  localparam int unsigned MAX_CPU_BURST_DEF = 8;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters (CPU, DMA/loader), the arbiter and memory decode.
//   master modport : the CPU/DMA/memory side (drives requests and mem_rdata_i)
//   slave modport  : the arbiter (drives grants, rvalids, muxed memory strobes)
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = mem_bus_arbiter_pkg::ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = mem_bus_arbiter_pkg::DATA_WIDTH_DEF
);
  import mem_bus_arbiter_pkg::*;

  logic                  cpu_req_i;
  logic                  cpu_we_i;
  logic [ADDR_WIDTH-1:0] cpu_addr_i;
  logic [DATA_WIDTH-1:0] cpu_wdata_i;
  logic                  cpu_lock_i;
  logic                  cpu_halt_i;
  logic                  cpu_gnt_o;
  logic                  cpu_rvalid_o;

  logic                  dma_req_i;
  logic                  dma_we_i;
  logic [ADDR_WIDTH-1:0] dma_addr_i;
  logic [DATA_WIDTH-1:0] dma_wdata_i;
  logic                  dma_gnt_o;
  logic                  dma_rvalid_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic                  mem_we_o;
  logic                  mem_re_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  bus_owner_t            owner_o;

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_lock_i, cpu_halt_i,
    output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    output mem_rdata_i,
    input  cpu_gnt_o, cpu_rvalid_o, dma_gnt_o, dma_rvalid_o,
    input  mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o, rdata_o, owner_o
  );

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, cpu_lock_i, cpu_halt_i,
    input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
    input  mem_rdata_i,
    output cpu_gnt_o, cpu_rvalid_o, dma_gnt_o, dma_rvalid_o,
    output mem_addr_o, mem_we_o, mem_re_o, mem_wdata_o, rdata_o, owner_o
  );

endinterface

// File: rtl/mem_bus_arbiter_starve_counter.sv
// Counts consecutive CPU grants taken while the DMA port is waiting; sat flags that the
// DMA must get the next unlocked slot. Only built with ARB_STARVE_GUARD_EN.
//   clk, reset : clock, asynchronous active-low reset
//   cpu_gnt    : CPU grant being issued at this edge
//   dma_gnt    : DMA grant being issued at this edge
//   dma_req    : DMA request sampled at this edge
//   sat        : counter has reached MAX_CPU_BURST
`ifdef ARB_STARVE_GUARD_EN
module mem_bus_arbiter_starve_counter #(
  parameter int unsigned MAX_CPU_BURST = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_gnt,
  input  logic dma_gnt,
  input  logic dma_req,
  output logic sat
);

  localparam int unsigned CntW = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(MAX_CPU_BURST);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (dma_gnt || !dma_req) begin
      cnt_d = '0;
    end else if (cpu_gnt && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign sat = (cnt_q == CntMax);

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Shares the single memory bus between the CPU and the DMA/debug-loader port, one access per
// granted cycle. Fixed priority to the CPU; a CPU lock keeps the bus across multi-byte fetches;
// a halted CPU has its requests and lock ignored.
// Build option: define ARB_STARVE_GUARD_EN to force a waiting DMA in after MAX_CPU_BURST
// consecutive CPU grants (no forcing while a lock is active).
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : mem_bus_arbiter_if.slave (requests in, grants/rvalids/muxed memory strobes out)
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int unsigned MAX_CPU_BURST = MAX_CPU_BURST_DEF
) (
  input  logic             clk,
  input  logic             reset,
  mem_bus_arbiter_if.slave bus
);

  if (MAX_CPU_BURST < 1) begin : g_bad_burst
    $error("MAX_CPU_BURST must be at least 1");
  end

  bus_owner_t owner_q, owner_d;
  logic       cpu_gnt_q, cpu_gnt_d;
  logic       dma_gnt_q, dma_gnt_d;
  logic       cpu_rvalid_q, dma_rvalid_q;
  logic       cpu_ok, lock_hold, starve_sat;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_we, mem_re;

`ifdef ARB_STARVE_GUARD_EN
  mem_bus_arbiter_starve_counter #(
    .MAX_CPU_BURST (MAX_CPU_BURST)
  ) u_arb_starve_counter (
    .clk     (clk),
    .reset   (reset),
    .cpu_gnt (cpu_gnt_d),
    .dma_gnt (dma_gnt_d),
    .dma_req (bus.dma_req_i),
    .sat     (starve_sat)
  );
`else
  assign starve_sat = 1'b0;
`endif

  // Slot decision for the cycle after this edge.
  always_comb begin
    cpu_ok    = bus.cpu_req_i & ~bus.cpu_halt_i;
    // The lock only holds while the CPU already owns the bus and is not halted.
    lock_hold = (owner_q == OWNER_CPU) & bus.cpu_lock_i & ~bus.cpu_halt_i;
    owner_d   = OWNER_NONE;
    cpu_gnt_d = 1'b0;
    dma_gnt_d = 1'b0;
    if (lock_hold) begin
      // Owner stays CPU even in an idle slot so the DMA cannot slip in.
      owner_d   = OWNER_CPU;
      cpu_gnt_d = cpu_ok;
    end else if (starve_sat && bus.dma_req_i) begin
      owner_d   = OWNER_DMA;
      dma_gnt_d = 1'b1;
    end else if (cpu_ok) begin
      owner_d   = OWNER_CPU;
      cpu_gnt_d = 1'b1;
    end else if (bus.dma_req_i) begin
      owner_d   = OWNER_DMA;
      dma_gnt_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q      <= OWNER_NONE;
      cpu_gnt_q    <= 1'b0;
      dma_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
    end else begin
      owner_q      <= owner_d;
      cpu_gnt_q    <= cpu_gnt_d;
      dma_gnt_q    <= dma_gnt_d;
      // Read data arrives one cycle after the strobe; writes never produce rvalid.
      cpu_rvalid_q <= cpu_gnt_q & ~bus.cpu_we_i;
      dma_rvalid_q <= dma_gnt_q & ~bus.dma_we_i;
    end
  end

  // Memory side is driven only during a grant cycle, otherwise parked at zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (cpu_gnt_q) begin
      mem_addr  = bus.cpu_addr_i;
      mem_wdata = bus.cpu_wdata_i;
      mem_we    = bus.cpu_we_i;
      mem_re    = ~bus.cpu_we_i;
    end else if (dma_gnt_q) begin
      mem_addr  = bus.dma_addr_i;
      mem_wdata = bus.dma_wdata_i;
      mem_we    = bus.dma_we_i;
      mem_re    = ~bus.dma_we_i;
    end
  end

  assign bus.cpu_gnt_o    = cpu_gnt_q;
  assign bus.dma_gnt_o    = dma_gnt_q;
  assign bus.cpu_rvalid_o = cpu_rvalid_q;
  assign bus.dma_rvalid_o = dma_rvalid_q;
  assign bus.mem_addr_o   = mem_addr;
  assign bus.mem_wdata_o  = mem_wdata;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_re_o     = mem_re;
  assign bus.rdata_o      = bus.mem_rdata_i;
  assign bus.owner_o      = owner_q;

endmodule
